// File: rtl/sprite_mover.sv
// Sprite position/velocity engine, advanced once per video frame.
// Direction keys set the velocity. With no key pressed the sprite keeps
// its current velocity (coasts). At a screen edge the position is clamped
// and the velocity on that axis is reversed. The pause key toggles
// between RUN and PAUSED on its press edge only.
module sprite_mover #(
    parameter int         X_W       = 10,
    parameter int         Y_W       = 10,
    parameter int         X_MIN     = 0,
    parameter int         X_MAX     = 639,
    parameter int         Y_MIN     = 0,
    parameter int         Y_MAX     = 479,
    parameter int         X_CENTER  = 320,
    parameter int         Y_CENTER  = 240,
    parameter int         SIZE      = 4,
    parameter int         STEP      = 1,
    parameter logic [7:0] KEY_UP    = 8'd26,
    parameter logic [7:0] KEY_LEFT  = 8'd4,
    parameter logic [7:0] KEY_DOWN  = 8'd22,
    parameter logic [7:0] KEY_RIGHT = 8'd7,
    parameter logic [7:0] KEY_PAUSE = 8'd44
) (
    input  logic           frame_clk,
    input  logic           Reset,
    input  logic [7:0]     keycode,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic [9:0]     size,
    output logic           paused,
    output logic           bounce_x,
    output logic           bounce_y
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_PAUSED = 1'b1;

    // Legal centre range: the sprite edge may touch a limit but not cross it.
    localparam logic signed [X_W+1:0] X_HI   = (X_W+2)'(X_MAX - SIZE);
    localparam logic signed [X_W+1:0] X_LO   = (X_W+2)'(X_MIN + SIZE);
    localparam logic signed [Y_W+1:0] Y_HI   = (Y_W+2)'(Y_MAX - SIZE);
    localparam logic signed [Y_W+1:0] Y_LO   = (Y_W+2)'(Y_MIN + SIZE);
    localparam logic signed [X_W+1:0] STEP_X = (X_W+2)'(STEP);
    localparam logic signed [Y_W+1:0] STEP_Y = (Y_W+2)'(STEP);
    localparam logic [X_W-1:0]        X_RST  = X_W'(X_CENTER);
    localparam logic [Y_W-1:0]        Y_RST  = Y_W'(Y_CENTER);

    logic [0:0]              state;
    logic [7:0]              prev_key;
    logic signed [X_W+1:0]   vel_x;
    logic signed [Y_W+1:0]   vel_y;

    logic                    pause_edge;
    logic signed [X_W+1:0]   form_vx;
    logic signed [Y_W+1:0]   form_vy;
    logic signed [X_W+1:0]   cand_x;
    logic signed [Y_W+1:0]   cand_y;

    // True when the candidate puts the sprite edge strictly past a limit.
    function automatic logic hit_x(input logic signed [X_W+1:0] cand);
        return (cand > X_HI) || (cand < X_LO);
    endfunction

    function automatic logic hit_y(input logic signed [Y_W+1:0] cand);
        return (cand > Y_HI) || (cand < Y_LO);
    endfunction

    // Saturate a candidate centre into the legal range.
    function automatic logic [X_W-1:0] sat_x(input logic signed [X_W+1:0] cand);
        logic signed [X_W+1:0] r;
        if (cand > X_HI)      r = X_HI;
        else if (cand < X_LO) r = X_LO;
        else                  r = cand;
        return r[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] sat_y(input logic signed [Y_W+1:0] cand);
        logic signed [Y_W+1:0] r;
        if (cand > Y_HI)      r = Y_HI;
        else if (cand < Y_LO) r = Y_LO;
        else                  r = cand;
        return r[Y_W-1:0];
    endfunction

    assign size       = 10'(SIZE);
    assign paused     = (state == ST_PAUSED);
    assign pause_edge = (keycode == KEY_PAUSE) && (prev_key != KEY_PAUSE);

    // Form this frame's velocity from the key, then the unclamped next
    // position. The sum is two bits wider than the position, so it cannot wrap.
    always_comb begin
        form_vx = vel_x;
        form_vy = vel_y;
        if (keycode == KEY_UP) begin
            form_vx = '0;
            form_vy = -STEP_Y;
        end else if (keycode == KEY_DOWN) begin
            form_vx = '0;
            form_vy = STEP_Y;
        end else if (keycode == KEY_LEFT) begin
            form_vx = -STEP_X;
            form_vy = '0;
        end else if (keycode == KEY_RIGHT) begin
            form_vx = STEP_X;
            form_vy = '0;
        end
        cand_x = $signed({2'b00, pos_x}) + form_vx;
        cand_y = $signed({2'b00, pos_y}) + form_vy;
    end

    // Frame update. A pause edge wins over motion. A wall hit clamps the
    // position, reverses the formed velocity and raises a one-frame pulse.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state    <= ST_RUN;
            prev_key <= '0;
            pos_x    <= X_RST;
            pos_y    <= Y_RST;
            vel_x    <= '0;
            vel_y    <= '0;
            bounce_x <= 1'b0;
            bounce_y <= 1'b0;
        end else begin
            prev_key <= keycode;
            bounce_x <= 1'b0;
            bounce_y <= 1'b0;
            if (pause_edge) begin
                state <= (state == ST_RUN) ? ST_PAUSED : ST_RUN;
            end else if (state == ST_RUN) begin
                pos_x    <= sat_x(cand_x);
                pos_y    <= sat_y(cand_y);
                vel_x    <= hit_x(cand_x) ? -form_vx : form_vx;
                vel_y    <= hit_y(cand_y) ? -form_vy : form_vy;
                bounce_x <= hit_x(cand_x);
                bounce_y <= hit_y(cand_y);
            end
        end
    end

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover: a vector table for the frame-by-frame
// behaviour, plus longer hand-written runs into the screen edges.
module tb_sprite_mover;

    logic       frame_clk;
    logic       Reset;
    logic [7:0] keycode;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [9:0] size;
    logic       paused;
    logic       bounce_x;
    logic       bounce_y;

    int errors = 0;
    int checks = 0;

    sprite_mover dut (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .keycode  (keycode),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .size     (size),
        .paused   (paused),
        .bounce_x (bounce_x),
        .bounce_y (bounce_y)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic       rst;
        logic [7:0] key;
        int         x;
        int         y;
        int         p;
        int         bx;
        int         by;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply inputs for one frame and sample just after the edge.
    task automatic step(input logic r, input logic [7:0] k);
        Reset   = r;
        keycode = k;
        @(posedge frame_clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int x, input int y,
                           input int p, input int bx, input int by);
        chk({tag, " pos_x"},    int'(pos_x),    x);
        chk({tag, " pos_y"},    int'(pos_y),    y);
        chk({tag, " paused"},   int'(paused),   p);
        chk({tag, " bounce_x"}, int'(bounce_x), bx);
        chk({tag, " bounce_y"}, int'(bounce_y), by);
    endtask

    initial begin
        Reset   = 1'b1;
        keycode = 8'd0;

        // reset, idle
        vecs.push_back('{1'b1, 8'd0,  320, 240, 0, 0, 0});
        vecs.push_back('{1'b0, 8'd0,  320, 240, 0, 0, 0});
        vecs.push_back('{1'b0, 8'd0,  320, 240, 0, 0, 0});
        vecs.push_back('{1'b0, 8'd0,  320, 240, 0, 0, 0});
        // right held 5 frames, then coast 2
        vecs.push_back('{1'b0, 8'd7,  321, 240, 0, 0, 0});
        vecs.push_back('{1'b0, 8'd7,  322, 240, 0, 0, 0});
        vecs.push_back('{1'b0, 8'd7,  323, 240, 0, 0, 0});
        vecs.push_back('{1'b0, 8'd7,  324, 240, 0, 0, 0});
        vecs.push_back('{1'b0, 8'd7,  325, 240, 0, 0, 0});
        vecs.push_back('{1'b0, 8'd0,  326, 240, 0, 0, 0});
        vecs.push_back('{1'b0, 8'd0,  327, 240, 0, 0, 0});
        // up, down, coast down
        vecs.push_back('{1'b0, 8'd26, 327, 239, 0, 0, 0});
        vecs.push_back('{1'b0, 8'd22, 327, 240, 0, 0, 0});
        vecs.push_back('{1'b0, 8'd0,  327, 241, 0, 0, 0});
        // left then right: back to moving right at +1
        vecs.push_back('{1'b0, 8'd4,  326, 241, 0, 0, 0});
        vecs.push_back('{1'b0, 8'd7,  327, 241, 0, 0, 0});
        // pause held 3 frames toggles once, keys ignored while paused
        vecs.push_back('{1'b0, 8'd44, 327, 241, 1, 0, 0});
        vecs.push_back('{1'b0, 8'd44, 327, 241, 1, 0, 0});
        vecs.push_back('{1'b0, 8'd44, 327, 241, 1, 0, 0});
        vecs.push_back('{1'b0, 8'd0,  327, 241, 1, 0, 0});
        vecs.push_back('{1'b0, 8'd26, 327, 241, 1, 0, 0});
        vecs.push_back('{1'b0, 8'd0,  327, 241, 1, 0, 0});
        // unpause: no move on the edge frame, then resume at +1
        vecs.push_back('{1'b0, 8'd44, 327, 241, 0, 0, 0});
        vecs.push_back('{1'b0, 8'd44, 328, 241, 0, 0, 0});
        vecs.push_back('{1'b0, 8'd0,  329, 241, 0, 0, 0});
        // pause again, then reset while paused
        vecs.push_back('{1'b0, 8'd44, 329, 241, 1, 0, 0});
        vecs.push_back('{1'b0, 8'd0,  329, 241, 1, 0, 0});
        vecs.push_back('{1'b1, 8'd0,  320, 240, 0, 0, 0});
        vecs.push_back('{1'b0, 8'd0,  320, 240, 0, 0, 0});
        vecs.push_back('{1'b0, 8'd0,  320, 240, 0, 0, 0});

        @(negedge frame_clk);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].key);
            chk_all($sformatf("vec%0d", i), vecs[i].x, vecs[i].y,
                    vecs[i].p, vecs[i].bx, vecs[i].by);
        end
        chk("size", int'(size), 4);

        // Left wall: coast from 5 at -1 to touch, then bounce.
        step(1'b1, 8'd0);
        for (int n = 0; n < 315; n++) step(1'b0, 8'd4);
        chk_all("lw approach", 5, 240, 0, 0, 0);
        step(1'b0, 8'd0);
        chk_all("lw touch", 4, 240, 0, 0, 0);
        step(1'b0, 8'd0);
        chk_all("lw bounce", 4, 240, 0, 1, 0);
        step(1'b0, 8'd0);
        chk_all("lw rebound", 5, 240, 0, 0, 0);
        step(1'b0, 8'd0);
        chk_all("lw coast", 6, 240, 0, 0, 0);

        // Right wall: hold right into the wall.
        step(1'b1, 8'd0);
        for (int n = 0; n < 315; n++) step(1'b0, 8'd7);
        chk_all("rw reach", 635, 240, 0, 0, 0);
        for (int n = 0; n < 4; n++) begin
            step(1'b0, 8'd7);
            chk_all($sformatf("rw hold%0d", n), 635, 240, 0, 1, 0);
        end
        step(1'b0, 8'd0);
        chk_all("rw release", 634, 240, 0, 0, 0);

        // Top wall: hold up into the wall, then release and coast down.
        step(1'b1, 8'd0);
        for (int n = 0; n < 236; n++) step(1'b0, 8'd26);
        chk_all("tw reach", 320, 4, 0, 0, 0);
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 8'd26);
            chk_all($sformatf("tw hold%0d", n), 320, 4, 0, 0, 1);
        end
        step(1'b0, 8'd0);
        chk_all("tw release", 320, 5, 0, 0, 0);

        // Reset in the middle of a bounce.
        step(1'b0, 8'd4);
        step(1'b1, 8'd26);
        chk_all("rst mid", 320, 240, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_mover.md
SPRITE_MOVER -- requirements
Module: sprite_mover

Interface
REQ-001 Parameter X_W, default 10: X position width in bits.
REQ-002 Parameter Y_W, default 10: Y position width in bits.
REQ-003 Parameters X_MIN/X_MAX, defaults 0/639: inclusive horizontal screen limits.
REQ-004 Parameters Y_MIN/Y_MAX, defaults 0/479: inclusive vertical screen limits.
REQ-005 Parameters X_CENTER/Y_CENTER, defaults 320/240: reset position.
REQ-006 Parameter SIZE, default 4: sprite half-extent in pixels, 1..15.
REQ-007 Parameter STEP, default 1: speed magnitude in pixels per frame, 1..15.
REQ-008 Parameters KEY_UP/KEY_LEFT/KEY_DOWN/KEY_RIGHT/KEY_PAUSE, defaults 26/4/22/7/44: USB HID keycodes.
REQ-009 frame_clk  in  1  the only clock; one rising edge per video frame.
REQ-010 Reset  in  1  synchronous, active-high reset, sampled on frame_clk rising edge.
REQ-011 keycode  in  8  current key; 0 means no key.
REQ-012 pos_x  out  X_W  registered sprite centre X.
REQ-013 pos_y  out  Y_W  registered sprite centre Y.
REQ-014 size  out  10  constant SIZE, zero-extended.
REQ-015 paused  out  1  high while in state PAUSED.
REQ-016 bounce_x / bounce_y  out  1 each  one-frame pulse on a frame where the X / Y clamp fired.

Function
REQ-017 The block SHALL keep signed velocity registers vel_x (X_W+2 bits) and vel_y (Y_W+2 bits).
REQ-018 The state machine SHALL have two states: RUN and PAUSED.
REQ-019 Pause edge = keycode==KEY_PAUSE this frame and the registered previous keycode != KEY_PAUSE.
REQ-020 On a pause edge the block SHALL toggle RUN<->PAUSED; holding KEY_PAUSE SHALL cause no further toggles.
REQ-021 In PAUSED, pos_x, pos_y, vel_x and vel_y SHALL hold; bounce_x and bounce_y SHALL be 0; direction keys SHALL be ignored.
REQ-022 In RUN, first the key-selected velocity SHALL be formed:
- KEY_UP: (0,-STEP).
- KEY_DOWN: (0,+STEP).
- KEY_LEFT: (-STEP,0).
- KEY_RIGHT: (+STEP,0).
- Any other value: current velocity unchanged (coast).
REQ-023 The candidate position SHALL be the current position plus the velocity formed in the same frame; this is the key-selected velocity, not the stale registered one. The sum SHALL be computed signed at width+2 with no wrap-around.
REQ-024 X clamp, right side: if candidate+SIZE > X_MAX, the block SHALL set pos_x=X_MAX-SIZE, set vel_x to the negated formed velocity, and pulse bounce_x.
REQ-025 X clamp, left side: if candidate-SIZE < X_MIN, the block SHALL set pos_x=X_MIN+SIZE, set vel_x to the negated formed velocity, and pulse bounce_x.
REQ-026 Otherwise the block SHALL set pos_x=candidate and vel_x=formed velocity.
REQ-027 Y SHALL follow REQ-024..026 independently, using Y_MIN/Y_MAX, pos_y, vel_y and bounce_y.
REQ-028 Touching a limit exactly (candidate±SIZE == limit) SHALL NOT count as a bounce.
REQ-029 A direction key held into a wall SHALL keep the position at the clamp value and pulse bounce every frame, with no jitter.
REQ-030 All outputs SHALL be registered; a position change SHALL be visible on the first frame_clk edge after keycode is sampled, giving 1-frame latency.
REQ-031 If a pause edge and a direction key occur in the same frame (impossible with one keycode), the pause edge SHALL take priority.

Reset
REQ-032 When Reset=1 at an edge, the block SHALL load pos=(X_CENTER,Y_CENTER), vel=(0,0), state=RUN, bounce_x=bounce_y=0, previous keycode=0, and size stays SIZE.
REQ-033 Reset SHALL override every other input, including in PAUSED and mid-bounce.

Verification
REQ-034 Reset high for 1 frame, then keycode=0 for 3 frames -> pos=(320,240) every frame, paused=0, no bounce pulses.
REQ-035 keycode=7 held for 5 frames, then 0 for 2 frames -> pos_x=325 after 5 frames, 327 after 7 frames (coasting), pos_y=240.
REQ-036 pos_x=5 with vel_x=-1, keycode=0 -> next frame pos_x=4; following frame pos_x=4 with bounce_x=1 for 1 frame and vel_x=+1; frame after that pos_x=5.
REQ-037 pos_x=635, keycode=7 held for 4 frames -> pos_x stays 635 and bounce_x=1 on all 4 frames.
REQ-038 Moving right at vel_x=+1, keycode=44 held 3 frames -> paused=1 and pos frozen. Then keycode=0 followed by 44 -> paused=0 and motion resumes from the frozen position at vel_x=+1.
REQ-039 Reset asserted in PAUSED while mid-screen -> next frame paused=0, pos=(320,240), vel=(0,0).
